// File: rtl/ucaspian_synapse_if.sv
// Handshake bundle between the axon, the synapse dispatch stage and the dendrite stage.
// Carries the incoming synapse range (syn_*) and the outgoing weighted events (dend_*).
// slave : view of the synapse stage (accepts ranges, produces events)
// master: view of the surrounding logic / bench (produces ranges, accepts events)
interface ucaspian_synapse_if #(
    parameter int SYN_AW = 12,
    parameter int NRN_W  = 8,
    parameter int WGT_W  = 8
);
    logic [SYN_AW-1:0] syn_start;
    logic [SYN_AW-1:0] syn_end;
    logic              syn_vld;
    logic              syn_rdy;
    logic [NRN_W-1:0]  dend_addr;
    logic [WGT_W-1:0]  dend_weight;
    logic              dend_vld;
    logic              dend_rdy;

    modport slave (
        input  syn_start, syn_end, syn_vld, dend_rdy,
        output syn_rdy, dend_addr, dend_weight, dend_vld
    );

    modport master (
        output syn_start, syn_end, syn_vld, dend_rdy,
        input  syn_rdy, dend_addr, dend_weight, dend_vld
    );
endinterface

// File: rtl/ucaspian_synapse.sv
// Synapse dispatch stage: walks the synapse RAM over an inclusive (wrapping) index range
// and emits one (target neuron, signed weight) event per synapse through a 2-entry FIFO.
// Also owns synapse configuration writes, RAM clearing and step-done reporting.
// Optional feature macro: UCASPIAN_SYN_ZERO_SKIP_EN -- when defined, words whose weight
// is zero are dropped on read return instead of being pushed into the output FIFO.
module ucaspian_synapse #(
    parameter int SYN_AW = 12,
    parameter int NRN_W  = 8,
    parameter int WGT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_act,
    input  logic              clear_config,
    output logic              clear_done,
    input  logic [SYN_AW-1:0] config_addr,
    input  logic [7:0]        config_value,
    input  logic [2:0]        config_byte,
    input  logic              config_enable,
    input  logic              next_step,
    output logic              step_done,
    ucaspian_synapse_if.slave bus
);

    localparam int WORD_W = NRN_W + WGT_W;
    localparam int DEPTH  = 1 << SYN_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [SYN_AW-1:0] cur;
    logic [SYN_AW-1:0] last;
    logic              clearing;
    logic              syn_rdy_c;
    logic              accept;
    logic              rd_en;
    logic              rd_vld;
    logic [WORD_W-1:0] rd_data;
    logic [WORD_W-1:0] mem [DEPTH];

    logic [WORD_W-1:0] fifo_mem [2];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              keep;
    logic [2:0]        credit_used;

    logic [NRN_W-1:0]  stage_tgt;
    logic [WGT_W-1:0]  stage_wgt;
    logic              commit_pend;
    logic [SYN_AW-1:0] commit_addr;
    logic              cfg_stb;
    logic              wr_en;
    logic [SYN_AW-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    logic [SYN_AW:0]   clr_cnt;
    logic              act_seen;

    assign clearing   = clear_act | clear_config;
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign pop        = ~fifo_empty & bus.dend_rdy;
    assign accept     = bus.syn_vld & syn_rdy_c;
    assign cfg_stb    = config_enable & ~clearing;

    // A read counts against the FIFO until its data lands; a pop this cycle frees a slot.
    assign credit_used = 3'(fifo_cnt) + 3'(rd_vld) - 3'(pop);

`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
    assign keep = (rd_data[WGT_W-1:0] != '0);
`else
    assign keep = 1'b1;
`endif

    assign push = rd_vld & ~clearing & keep;

    assign bus.syn_rdy     = syn_rdy_c;
    assign bus.dend_vld    = ~fifo_empty;
    assign bus.dend_addr   = fifo_mem[fifo_rd_ptr][WORD_W-1:WGT_W];
    assign bus.dend_weight = fifo_mem[fifo_rd_ptr][WGT_W-1:0];

    // FSM state register; reset abandons any walk in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: a clear always returns to IDLE, otherwise accept -> walk -> drain -> idle.
    always_comb begin
        state_next = state;
        if (clearing) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = WALK;
                WALK:    if (rd_en && (cur == last)) state_next = DRAIN;
                DRAIN:   if (fifo_empty && !rd_vld) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: range ready only when idle, and RAM reads only while walking with credit.
    always_comb begin
        syn_rdy_c = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE:    syn_rdy_c = enable & ~clearing;
            WALK:    rd_en     = ~clearing & (credit_used < 3'd2);
            default: ;
        endcase
    end

    // Walk pointer: latch the range on accept, step modulo the RAM depth on each issued read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur  <= '0;
            last <= '0;
        end else if (accept) begin
            cur  <= bus.syn_start;
            last <= bus.syn_end;
        end else if (rd_en) begin
            cur  <= cur + SYN_AW'(1);
        end
    end

    // Tracks the single read in flight so its data can be pushed (or discarded on clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
        end
    end

    // Synapse RAM read port, 1-cycle latency, returns the old word on a same-index write.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[cur];
        end
    end

    // Synapse RAM write port, shared by the clear sweep and configuration commits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write port arbitration: the clear sweep wins, and any clear suppresses a pending commit.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = commit_addr;
        wr_data = {stage_tgt, stage_wgt};
        if (clear_config) begin
            if (!clr_cnt[SYN_AW]) begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt[SYN_AW-1:0];
                wr_data = '0;
            end
        end else if (commit_pend && !clear_act) begin
            wr_en = 1'b1;
        end
    end

    // Output FIFO: two entries so the credit scheme never loses a returning read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else if (clearing) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= rd_data;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    // Configuration staging: byte 1 zeroes, byte 2 sets target, byte 3 sets weight and commits next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_tgt   <= '0;
            stage_wgt   <= '0;
            commit_pend <= 1'b0;
            commit_addr <= '0;
        end else begin
            commit_pend <= cfg_stb && (config_byte == 3'd3);
            if (cfg_stb) begin
                case (config_byte)
                    3'd1: begin
                        stage_tgt <= '0;
                        stage_wgt <= '0;
                    end
                    3'd2: stage_tgt <= config_value[NRN_W-1:0];
                    3'd3: begin
                        stage_wgt   <= config_value[WGT_W-1:0];
                        commit_addr <= config_addr;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Clear sequencing: sweep counter for the RAM wipe and the clear_done handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt    <= '0;
            act_seen   <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            if (!clear_config) begin
                clr_cnt <= '0;
            end else if (!clr_cnt[SYN_AW]) begin
                clr_cnt <= clr_cnt + (SYN_AW+1)'(1);
            end
            act_seen   <= clear_act;
            clear_done <= clear_config ? clr_cnt[SYN_AW] : (clear_act & act_seen);
        end
    end

    // Step-done: stage idle with nothing queued or arriving, held low right after a step boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_done <= 1'b0;
        end else if (next_step) begin
            step_done <= 1'b0;
        end else begin
            step_done <= (state == IDLE) && fifo_empty && !bus.syn_vld && !clearing;
        end
    end

endmodule

// File: tb/tb_ucaspian_synapse.sv
// Self-checking bench for ucaspian_synapse: table of directed ranges plus hand sequences
// for back-pressure, clear_act, clear_config, enable gating and step_done.
module tb_ucaspian_synapse;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        clear_act;
    logic        clear_config;
    logic        clear_done;
    logic [11:0] config_addr;
    logic [7:0]  config_value;
    logic [2:0]  config_byte;
    logic        config_enable;
    logic        next_step;
    logic        step_done;

    ucaspian_synapse_if #(.SYN_AW(12), .NRN_W(8), .WGT_W(8)) bus ();

    ucaspian_synapse #(.SYN_AW(12), .NRN_W(8), .WGT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .clear_act     (clear_act),
        .clear_config  (clear_config),
        .clear_done    (clear_done),
        .config_addr   (config_addr),
        .config_value  (config_value),
        .config_byte   (config_byte),
        .config_enable (config_enable),
        .next_step     (next_step),
        .step_done     (step_done),
        .bus           (bus)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wgt;
        int         vis;
    } ev_t;

    typedef struct {
        string      name;
        logic [11:0] s;
        logic [11:0] e;
        int         n;
        logic [63:0] evs;
    } vec_t;

    ev_t  evq[$];
    int   cyc;
    int   acc_edge;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure event latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Records accepts and completed dendrite handshakes, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.syn_vld && bus.syn_rdy) acc_edge = cyc + 1;
        if (bus.dend_vld && bus.dend_rdy) evq.push_back('{bus.dend_addr, bus.dend_weight, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic configWrite(input logic [11:0] idx, input logic [7:0] tgt, input logic [7:0] wgt);
        config_enable = 1'b1;
        config_addr   = idx;
        config_byte   = 3'd1;
        config_value  = 8'h00;
        tick();
        config_byte  = 3'd2;
        config_value = tgt;
        tick();
        config_byte  = 3'd3;
        config_value = wgt;
        tick();
        config_enable = 1'b0;
        config_byte   = 3'd0;
        tick();
    endtask

    task automatic applyStimulus(input string name, input logic [11:0] s, input logic [11:0] e);
        bit acc;
        acc           = 1'b0;
        bus.syn_start = s;
        bus.syn_end   = e;
        bus.syn_vld   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (bus.syn_rdy) begin
                tick();
                acc = 1'b1;
                break;
            end
            tick();
        end
        bus.syn_vld = 1'b0;
        checkOutput($sformatf("%s accept", name), 32'(acc), 32'd1);
    endtask

    task automatic waitIdle(input string name);
        for (int k = 0; k < 300; k++) begin
            if (step_done) break;
            tick();
        end
        checkOutput($sformatf("%s idle", name), 32'(step_done), 32'd1);
    endtask

    task automatic checkEvents(input string name, input int n, input logic [63:0] evs);
        logic [63:0] ev_loc;
        ev_loc = evs;
        checkOutput($sformatf("%s count", name), 32'(evq.size()), 32'(n));
        for (int j = 0; j < n && j < evq.size(); j++) begin
            checkOutput($sformatf("%s ev%0d", name, j), {16'h0, evq[j].addr, evq[j].wgt},
                        {16'h0, ev_loc[16*j +: 16]});
        end
    endtask

    vec_t vecs[5];

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        acc_edge = 0;
        vecs[0] = '{"r10_12",  12'd10,   12'd12,  3, {16'h0000, 16'h077F, 16'h06FF, 16'h0503}};
        vecs[1] = '{"wrap",    12'd4094, 12'd1,   4, {16'h7788, 16'h5566, 16'h3344, 16'h1122}};
        vecs[2] = '{"single",  12'd11,   12'd11,  1, {16'h0000, 16'h0000, 16'h0000, 16'h06FF}};
        vecs[3] = '{"r0_1",    12'd0,    12'd1,   2, {16'h0000, 16'h0000, 16'h7788, 16'h5566}};
        vecs[4] = '{"neg128",  12'd100,  12'd100, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0980}};

        reset         = 1'b0;
        enable        = 1'b1;
        clear_act     = 1'b0;
        clear_config  = 1'b0;
        config_addr   = '0;
        config_value  = '0;
        config_byte   = '0;
        config_enable = 1'b0;
        next_step     = 1'b0;
        bus.syn_start = '0;
        bus.syn_end   = '0;
        bus.syn_vld   = 1'b0;
        bus.dend_rdy  = 1'b1;

        // Reset values.
        repeat (3) tick();
        checkOutput("rst dend_vld", 32'(bus.dend_vld), 32'd0);
        checkOutput("rst dend_addr", 32'(bus.dend_addr), 32'd0);
        checkOutput("rst dend_weight", 32'(bus.dend_weight), 32'd0);
        checkOutput("rst step_done", 32'(step_done), 32'd0);
        checkOutput("rst clear_done", 32'(clear_done), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("rst syn_rdy", 32'(bus.syn_rdy), 32'd1);
        checkOutput("rst step_done up", 32'(step_done), 32'd1);

        // Load synapse RAM.
        configWrite(12'd10,   8'd5,   8'h03);
        configWrite(12'd11,   8'd6,   8'hFF);
        configWrite(12'd12,   8'd7,   8'h7F);
        configWrite(12'd4094, 8'h11,  8'h22);
        configWrite(12'd4095, 8'h33,  8'h44);
        configWrite(12'd0,    8'h55,  8'h66);
        configWrite(12'd1,    8'h77,  8'h88);
        configWrite(12'd100,  8'h09,  8'h80);

        // Directed range table with dend_rdy held high.
        for (int i = 0; i < 5; i++) begin
            evq.delete();
            applyStimulus(vecs[i].name, vecs[i].s, vecs[i].e);
            waitIdle(vecs[i].name);
            checkEvents(vecs[i].name, vecs[i].n, vecs[i].evs);
            if (evq.size() == vecs[i].n) begin
                checkOutput($sformatf("%s first lat", vecs[i].name), 32'(evq[0].vis - acc_edge), 32'd2);
                checkOutput($sformatf("%s last lat", vecs[i].name),
                            32'(evq[vecs[i].n-1].vis - acc_edge), 32'(1 + vecs[i].n));
            end
        end

        // Back-pressure: dend_rdy low for 5 cycles, head must hold the first event.
        evq.delete();
        bus.dend_rdy = 1'b0;
        applyStimulus("bp", 12'd10, 12'd12);
        for (int k = 0; k < 5; k++) begin
            if (bus.dend_vld) checkOutput("bp head", {16'h0, bus.dend_addr, bus.dend_weight}, 32'h0503);
            tick();
        end
        checkOutput("bp vld stalled", 32'(bus.dend_vld), 32'd1);
        checkOutput("bp none taken", 32'(evq.size()), 32'd0);
        bus.dend_rdy = 1'b1;
        waitIdle("bp");
        checkEvents("bp", 3, {16'h0000, 16'h077F, 16'h06FF, 16'h0503});

        // clear_act mid-walk.
        evq.delete();
        bus.dend_rdy = 1'b0;
        applyStimulus("ca", 12'd4094, 12'd1);
        tick();
        tick();
        checkOutput("ca vld before", 32'(bus.dend_vld), 32'd1);
        clear_act = 1'b1;
        tick();
        checkOutput("ca vld flushed", 32'(bus.dend_vld), 32'd0);
        checkOutput("ca syn_rdy low", 32'(bus.syn_rdy), 32'd0);
        tick();
        checkOutput("ca clear_done", 32'(clear_done), 32'd1);
        clear_act = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (step_done) break;
        end
        checkOutput("ca step_done", 32'(step_done), 32'd1);
        checkOutput("ca clear_done drop", 32'(clear_done), 32'd0);
        bus.dend_rdy = 1'b1;
        repeat (4) tick();
        checkOutput("ca no stray", 32'(evq.size()), 32'd0);
        checkOutput("ca idle rdy", 32'(bus.syn_rdy), 32'd1);

        // step_done forced low after next_step.
        checkOutput("ns before", 32'(step_done), 32'd1);
        next_step = 1'b1;
        tick();
        next_step = 1'b0;
        checkOutput("ns forced low", 32'(step_done), 32'd0);
        tick();
        checkOutput("ns back high", 32'(step_done), 32'd1);

        // enable low blocks new ranges.
        evq.delete();
        enable        = 1'b0;
        bus.syn_start = 12'd10;
        bus.syn_end   = 12'd12;
        bus.syn_vld   = 1'b1;
        tick();
        checkOutput("en syn_rdy", 32'(bus.syn_rdy), 32'd0);
        repeat (4) tick();
        checkOutput("en no events", 32'(evq.size()), 32'd0);
        bus.syn_vld = 1'b0;
        enable      = 1'b1;
        tick();

        // Zero-weight synapse at index 11.
        configWrite(12'd11, 8'd6, 8'h00);
        evq.delete();
        applyStimulus("zero", 12'd10, 12'd12);
        waitIdle("zero");
`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
        checkEvents("zero", 2, {16'h0000, 16'h0000, 16'h077F, 16'h0503});
`else
        checkEvents("zero", 3, {16'h0000, 16'h077F, 16'h0600, 16'h0503});
`endif

        // clear_config sweep: clear_done after 4097 edges, then RAM reads back zero.
        clear_config = 1'b1;
        begin
            int n;
            n = 0;
            for (int k = 0; k < 5000; k++) begin
                tick();
                n++;
                if (clear_done) break;
            end
            checkOutput("cc edges", 32'(n), 32'd4097);
        end
        tick();
        checkOutput("cc held", 32'(clear_done), 32'd1);
        clear_config = 1'b0;
        tick();
        checkOutput("cc released", 32'(clear_done), 32'd0);
        evq.delete();
        applyStimulus("cc read", 12'd10, 12'd12);
        waitIdle("cc read");
`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
        checkEvents("cc read", 0, 64'h0);
`else
        checkEvents("cc read", 3, 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
